serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial N-bit subtractor, the inverse-operation companion to the team's clocked full adder. Computes `a - b` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. Operands are captured on a start handshake; the result is delivered in parallel with a one-cycle done pulse. Intended for area-constrained datapaths where one ripple cell time-shared over WIDTH cycles beats a parallel subtractor.

## Interface
- `WIDTH`, default 8, operand and result width in bits (≥ 2).

- `clock`  input  1  single system clock, all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  minuend; captured on accepted start.
- `b`  input  WIDTH  subtrahend; captured on accepted start.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse when the result is valid.
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH`; held until the next completion.
- `borrow_out`  output  1  final borrow; 1 iff `a < b` (unsigned); held with `diff`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 at an edge → load `a` and `b` into shift registers `sa` and `sb`; clear the borrow flop and the bit counter to 0; go to RUN. `start`=0 → stay in IDLE.
- RUN, one bit per edge:
  - `d = sa[0] ^ sb[0] ^ br`
  - `bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`
  - Shift `sa` and `sb` right by 1.
  - Shift `d` into the MSB of the internal result register `sr`.
  - `br <= bo`; counter increments.
- RUN, on the edge that processes bit WIDTH-1:
  - Copy the complete result (`sr` including the final `d`) to `diff`.
  - Set `borrow_out <= bo`.
  - Go to DONE.
- DONE: `done`=1 for exactly this one cycle. Next edge goes to IDLE unconditionally.
- `start` while in RUN or DONE is ignored; it is neither queued nor able to restart the operation.
- `a` and `b` may change freely after capture without affecting the result.
- Counter width is `$clog2(WIDTH)`. There is no wrap beyond WIDTH-1, because the transition to DONE occurs at count WIDTH-1.
- Reset (any state, including mid-RUN):
  - Next state is IDLE.
  - `busy`=0, `done`=0, `diff`=0, `borrow_out`=0.
  - `sa`, `sb`, `sr`, borrow flop and counter cleared.
  - The partial result is discarded.
  - If `reset` and `start` are both high on the same edge, reset wins.

## Timing
- Accepted start at edge k.
- `busy`=1 from after edge k through edge k+WIDTH.
- `diff`/`borrow_out` update at edge k+WIDTH; `done`=1 in the cycle following that edge.
- Back in IDLE after edge k+WIDTH+1. Earliest next accepted start is edge k+WIDTH+2.
- Total start-to-done latency is WIDTH+1 edges; throughput is one operation per WIDTH+2 cycles.
- `busy` and `done` are registered state decodes and are never high together.
- `diff` and `borrow_out` are registered and glitch-free; they hold their values through IDLE, RUN and DONE until overwritten.

## Test plan
- WIDTH=8, `a`=5, `b`=3, single start pulse → after 9 edges: `done` pulse, `diff`=0x02, `borrow_out`=0; `busy` high for exactly 8 cycles.
- `a`=3, `b`=5 → `diff`=0xFE, `borrow_out`=1. Also `a`=0x00, `b`=0x01 → `diff`=0xFF, `borrow_out`=1.
- `a`=0xFF, `b`=0xFF → `diff`=0x00, `borrow_out`=0.
- `a`=0x80, `b`=0x7F → `diff`=0x01, `borrow_out`=0.
- Start held high continuously → back-to-back operations with exactly one IDLE cycle between the `done` pulse and the next `busy`. Operands changed during RUN → no effect on the result.
- Start with `a`=9, `b`=4, then assert `reset` at edge k+4 → all outputs 0 and IDLE on the next edge, no `done` pulse. A fresh start then yields `diff`=0x05, `borrow_out`=0. Same-edge `reset`+`start` → stays in IDLE.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit unsigned subtractor. It computes a - b one bit per
//   clock, LSB first, using a single full-subtractor cell and a borrow flop.
//   Operands are captured when start is accepted. The result appears on diff
//   and borrow_out, and done pulses for one cycle when they are valid.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; diff/borrow_out hold the last result
//   RUN   | one bit processed per edge, counter tracks the bit index
//   DONE  | result valid, done high for this single cycle
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   operation request, sampled only in IDLE
//   a, b       in   minuend / subtrahend, captured on accepted start
//   busy       out  high while in RUN
//   done       out  one-cycle pulse in DONE
//   diff       out  (a - b) mod 2^WIDTH, held until the next completion
//   borrow_out out  1 iff a < b (unsigned), held with diff
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d, bo;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs.
    assign d        = sa[0] ^ sb[0] ^ br;
    assign bo       = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            // Flags are registered decodes of the next state, so they are
            // glitch-free and line up exactly with the state register.
            busy  <= (state_nx == RUN);
            done  <= (state_nx == DONE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= {d, sr[WIDTH-1:1]};
                    br  <= bo;
                    cnt <= cnt + CW'(1);
                    // The final d is not yet in sr, so it is merged in here.
                    if (last_bit) begin
                        diff       <= {d, sr[WIDTH-1:1]};
                        borrow_out <= bo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
